i2c_target: RTL and testbench

I2C target (slave) responder with an 8-bit register pointer and a byte-wide register-file port. It sits on the same open-drain SCL/SDA pins that our I2C controller drives. Exposing it lets the design itself be addressed by an external I2C master for register reads and writes. It supports 7-bit addressing, pointer auto-increment and repeated START, and does no clock stretching.

---
 rtl/i2c_target.sv | 159 +++++++++++++++
 tb/tb_i2c_target.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target (slave) with an 8-bit auto-incrementing register pointer and a
// byte-wide register-file port. 7-bit addressing, repeated START, no clock stretching.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);
   localparam logic [3:0] S_IDLE = 4'd0, S_DEV  = 4'd1, S_AACK = 4'd2, S_PTR  = 4'd3,
                          S_PACK = 4'd4, S_WR   = 4'd5, S_WACK = 4'd6, S_RD   = 4'd7,
                          S_RACK = 4'd8, S_IGN  = 4'd9;

   logic       r_scl_meta, r_scl_sync, r_scl_prev;
   logic       r_sda_meta, r_sda_sync, r_sda_prev;
   logic [3:0] r_state, r_cnt;
   logic [7:0] r_shift, r_tx, r_ptr, r_wdata;
   logic       r_rw, r_ack_drv, r_oe, r_we, r_re, r_re_pend, r_load, r_busy;
   logic       w_scl_hi, w_start, w_stop, w_rise, w_fall, w_last;
   logic [7:0] w_byte;

   // Synchronizers free-run through reset so a stale pad level never looks like an edge.
   always_ff @(posedge clk) begin
      r_scl_meta <= scl_i;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= sda_i;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
   end

   assign w_scl_hi = r_scl_sync & r_scl_prev;
   assign w_start  = w_scl_hi & r_sda_prev & ~r_sda_sync;
   assign w_stop   = w_scl_hi & ~r_sda_prev & r_sda_sync;
   assign w_rise   = r_scl_sync & ~r_scl_prev;
   assign w_fall   = ~r_scl_sync & r_scl_prev;
   assign w_byte   = {r_shift[6:0], r_sda_sync};
   assign w_last   = (r_cnt == 4'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_shift   <= 8'h00;
         r_tx      <= 8'h00;
         r_ptr     <= 8'h00;
         r_wdata   <= 8'h00;
         r_rw      <= 1'b0;
         r_ack_drv <= 1'b0;
         r_oe      <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_re_pend <= 1'b0;
         r_load    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_we      <= 1'b0;
         r_re      <= r_re_pend;
         r_re_pend <= 1'b0;
         r_load    <= r_re;
         if (r_load) r_tx <= reg_rdata;
         if (r_we)   r_ptr <= r_ptr + 8'd1;
         if (w_start) begin
            r_state <= S_DEV;
            r_cnt   <= 4'd0;
            r_oe    <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_re_pend <= 1'b0;
         end else begin
            case (r_state)
               S_DEV, S_PTR, S_WR: if (w_rise) begin
                  r_shift <= w_byte;
                  r_cnt   <= r_cnt + 4'd1;
                  if (w_last) begin
                     r_cnt     <= 4'd0;
                     r_ack_drv <= 1'b0;
                     if (r_state == S_DEV) begin
                        if (w_byte[7:1] == TARGET_ADDR) begin
                           r_state <= S_AACK;
                           r_rw    <= w_byte[0];
                           r_busy  <= 1'b1;
                        end else begin
                           r_state <= S_IGN;
                        end
                     end else if (r_state == S_PTR) begin
                        r_ptr   <= w_byte;
                        r_state <= S_PACK;
                     end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_byte;
                        r_state <= S_WACK;
                     end
                  end
               end
               // First fall drives ACK, second fall ends the ACK bit.
               S_AACK, S_PACK, S_WACK: if (w_fall) begin
                  if (!r_ack_drv) begin
                     r_oe      <= 1'b1;
                     r_ack_drv <= 1'b1;
                     if (r_state == S_AACK && r_rw) r_re <= 1'b1;
                  end else if (r_state == S_AACK && r_rw) begin
                     r_oe    <= ~r_tx[7];
                     r_tx    <= {r_tx[6:0], 1'b0};
                     r_cnt   <= 4'd1;
                     r_state <= S_RD;
                  end else begin
                     r_oe    <= 1'b0;
                     r_cnt   <= 4'd0;
                     r_state <= (r_state == S_AACK) ? S_PTR : S_WR;
                  end
               end
               S_RD: if (w_fall) begin
                  if (r_cnt == 4'd8) begin
                     r_oe    <= 1'b0;
                     r_state <= S_RACK;
                  end else begin
                     r_oe  <= ~r_tx[7];
                     r_tx  <= {r_tx[6:0], 1'b0};
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               S_RACK: if (w_rise) begin
                  r_ptr <= r_ptr + 8'd1;
                  if (!r_sda_sync) begin
                     r_re_pend <= 1'b1;
                     r_cnt     <= 4'd0;
                     r_state   <= S_RD;
                  end else begin
                     r_state <= S_IGN;
                  end
               end
               S_IDLE, S_IGN: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign sda_o     = 1'b0;
   assign sda_oe    = r_oe;
   assign reg_addr  = r_ptr;
   assign reg_wdata = r_wdata;
   assign reg_we    = r_we;
   assign reg_re    = r_re;
   assign busy      = r_busy;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, transaction-level model of
// pointer/data behaviour, fixed scenarios plus randomized transactions.
module tb_i2c_target;
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_o, sda_oe, reg_we, reg_re, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       re_d = 1'b0;
   logic [7:0] ra_d = 8'h00;
   logic       prev_we = 1'b0, prev_re = 1'b0;
   int         n_tot = 0, n_bad = 0;
   int         oe_cnt = 0, ovl_cnt = 0, dbl_cnt = 0;
   logic [15:0] we_q[$];
   logic [7:0]  re_q[$];
   logic [7:0]  wbuf[$];
   logic [7:0]  m_ptr = 8'h00;

   wire sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   // Register file: data (addr ^ 0xFF) is presented only on the cycle after reg_re.
   always @(posedge clk) begin
      re_d <= reg_re;
      ra_d <= reg_addr;
   end
   assign reg_rdata = re_d ? ~ra_d : 8'h3C;

   always @(negedge clk) if (!reset) begin
      if (reg_we) we_q.push_back({reg_addr, reg_wdata});
      if (reg_re) re_q.push_back(reg_addr);
      if (reg_we && reg_re) ovl_cnt <= ovl_cnt + 1;
      if ((reg_we && prev_we) || (reg_re && prev_re)) dbl_cnt <= dbl_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      prev_we <= reg_we;
      prev_re <= reg_re;
   end

   i2c_target #(.TARGET_ADDR(7'h50)) dut (
      .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1; tick(8);
         scl_m = 1'b1; tick(8);
      end
      sda_m = 1'b0; tick(8);
      scl_m = 1'b0; tick(2);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(8);
      scl_m = 1'b1; tick(8);
      sda_m = 1'b1; tick(8);
   endtask

   task automatic bit_cyc(input logic b, output logic smp);
      sda_m = b;    tick(8);
      scl_m = 1'b1; tick(4);
      smp = sda_bus; tick(4);
      scl_m = 1'b0; tick(2);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) bit_cyc(b[i], d);
      bit_cyc(1'b1, ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic x;
      for (int i = 7; i >= 0; i--) bit_cyc(1'b1, d[i]);
      bit_cyc(nack, x);
   endtask

   // Writes wbuf starting at ptr; model: one strobe per byte at ptr+i, pointer ends at ptr+n.
   task automatic do_write(input logic [7:0] ptr);
      logic a;
      int   w0, r0, n;
      w0 = we_q.size(); r0 = re_q.size(); n = wbuf.size();
      bus_start();
      write_byte(8'hA0, a); chk("w_addr_ack", a, 0);
      chk("w_busy", busy, 1);
      write_byte(ptr, a);   chk("w_ptr_ack", a, 0);
      foreach (wbuf[i]) begin
         write_byte(wbuf[i], a); chk("w_data_ack", a, 0);
      end
      bus_stop();
      chk("w_busy_stop", busy, 0);
      chk("w_we_count", 16'(we_q.size() - w0), 16'(n));
      for (int i = 0; i < n && w0 + i < we_q.size(); i++)
         chk("w_strobe", we_q[w0 + i], {8'(ptr + i), wbuf[i]});
      chk("w_no_re", 16'(re_q.size() - r0), 0);
      m_ptr = 8'(ptr + n);
      chk("w_ptr_end", reg_addr, m_ptr);
   endtask

   // Reads n bytes, optionally after setting the pointer with a repeated START.
   task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
      logic       a;
      logic [7:0] d, base;
      int         w0, r0;
      w0 = we_q.size(); r0 = re_q.size();
      bus_start();
      if (set_ptr) begin
         write_byte(8'hA0, a); chk("r_waddr_ack", a, 0);
         write_byte(ptr, a);   chk("r_ptr_ack", a, 0);
         bus_start();
         base = ptr;
      end else begin
         base = m_ptr;
      end
      write_byte(8'hA1, a); chk("r_addr_ack", a, 0);
      chk("r_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, i == n - 1);
         chk("r_data", d, 8'(base + i) ^ 8'hFF);
      end
      tick(6);
      chk("r_release", sda_oe, 0);
      bus_stop();
      chk("r_busy_stop", busy, 0);
      chk("r_re_count", 16'(re_q.size() - r0), 16'(n));
      for (int i = 0; i < n && r0 + i < re_q.size(); i++)
         chk("r_re_addr", re_q[r0 + i], 8'(base + i));
      chk("r_no_we", 16'(we_q.size() - w0), 0);
      m_ptr = 8'(base + n);
      chk("r_ptr_end", reg_addr, m_ptr);
   endtask

   task automatic do_wrong(input logic [7:0] addr);
      logic a;
      int   w0, r0, o0;
      w0 = we_q.size(); r0 = re_q.size(); o0 = oe_cnt;
      bus_start();
      write_byte(addr, a);                 chk("x_nack", a, 1);
      write_byte(8'($urandom), a);         chk("x_nack2", a, 1);
      chk("x_busy", busy, 0);
      bus_stop();
      chk("x_oe_never", 16'(oe_cnt - o0), 0);
      chk("x_no_strobe", 16'((we_q.size() - w0) + (re_q.size() - r0)), 0);
      chk("x_ptr", reg_addr, m_ptr);
   endtask

   initial begin
      logic       a, x;
      logic [7:0] wa;
      int         w0, r0, o0;
      tick(4);
      chk("rst_oe", sda_oe, 0);     chk("rst_sda_o", sda_o, 0);
      chk("rst_we", reg_we, 0);     chk("rst_re", reg_re, 0);
      chk("rst_busy", busy, 0);     chk("rst_addr", reg_addr, 0);
      chk("rst_wdata", reg_wdata, 0);
      reset = 1'b0;
      tick(4);

      wbuf = {8'h5A, 8'hC3};
      do_write(8'h10);
      do_read(1'b1, 8'h10, 2);
      do_wrong(8'hA4);
      wbuf = {8'($urandom), 8'($urandom)};
      do_write(8'hFF);

      // STOP after four data bits: no strobe, pointer keeps loaded value.
      w0 = we_q.size();
      bus_start();
      write_byte(8'hA0, a); chk("p_addr_ack", a, 0);
      write_byte(8'h33, a); chk("p_ptr_ack", a, 0);
      for (int i = 0; i < 4; i++) bit_cyc(1'($urandom), x);
      bus_stop();
      chk("p_no_we", 16'(we_q.size() - w0), 0);
      chk("p_busy", busy, 0);
      m_ptr = 8'h33;
      chk("p_ptr", reg_addr, m_ptr);
      do_read(1'b0, 8'h00, 1);

      // Reset while driving a 0 bit of byte 0x7F (pointer 0x80).
      bus_start();
      write_byte(8'hA0, a); write_byte(8'h80, a);
      bus_start();
      write_byte(8'hA1, a); chk("z_addr_ack", a, 0);
      tick(4);
      chk("z_driving", sda_oe, 1);
      reset = 1'b1; tick(1); reset = 1'b0;
      chk("z_oe_rst", sda_oe, 0);
      chk("z_busy_rst", busy, 0);
      m_ptr = 8'h00;
      chk("z_ptr_rst", reg_addr, m_ptr);
      w0 = we_q.size(); r0 = re_q.size(); o0 = oe_cnt;
      for (int i = 0; i < 9; i++) bit_cyc(1'($urandom), x);
      bus_stop();
      chk("z_idle_oe", 16'(oe_cnt - o0), 0);
      chk("z_idle_strobe", 16'((we_q.size() - w0) + (re_q.size() - r0)), 0);
      do_read(1'b0, 8'h00, 1);

      for (int it = 0; it < 10; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               wbuf.delete();
               repeat ($urandom_range(1, 4)) wbuf.push_back(8'($urandom));
               do_write(8'($urandom));
            end
            1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
            2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
            default: begin
               wa = 8'($urandom);
               if (wa[7:1] == 7'h50) wa[7] = 1'b0;
               do_wrong(wa);
            end
         endcase
      end

      chk("strobe_overlap", 16'(ovl_cnt), 0);
      chk("strobe_width", 16'(dbl_cnt), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
